uart_loader: RTL and testbench

//  Sequences the UART receive datapath into a memory-load controller. Consumes received bytes,

---
 rtl/loader_pkg.sv | 21 ++
 rtl/byte_event_det.sv | 33 +++
 rtl/uart_loader.sv | 178 +++++++++++++++++
 tb/tb_uart_loader.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the UART memory loader.
//   state_t  : loader FSM state encoding
//   CMD_IMEM : command byte selecting instruction memory
//   CMD_DMEM : command byte selecting data memory
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] CMD_IMEM = 8'h01;
  localparam logic [7:0] CMD_DMEM = 8'h02;

endpackage

// File: rtl/byte_event_det.sv
// Turns the receiver's level-type byte-complete flag into a single-cycle
// byte event and captures the byte that goes with it.
//   sys_clk    in   clock
//   sys_rst_n  in   asynchronous active-low reset
//   rx_done    in   receiver byte-complete level
//   rx_data    in   received byte, valid while rx_done=1
//   byte_evt   out  one-cycle pulse, one per rising edge of rx_done
//   byte_data  out  byte captured in the rising-edge cycle
module byte_event_det (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       byte_evt,
  output logic [7:0] byte_data
);

  logic rx_done_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_done_q <= 1'b0;
      byte_evt  <= 1'b0;
      byte_data <= 8'h00;
    end else begin
      rx_done_q <= rx_done;
      byte_evt  <= rx_done & ~rx_done_q;
      if (rx_done & ~rx_done_q)
        byte_data <= rx_data;
    end
  end

endmodule

// File: rtl/uart_loader.sv
// Framed UART memory loader. Parses SYNC, CMD, LEN_LO, LEN_HI, LEN*4 data
// bytes and an XOR checksum, writing little-endian words to IMEM or DMEM and
// holding the core in reset while a load is in progress.
//
// state | meaning
// IDLE  | waiting for SYNC_BYTE, everything else ignored
// CMD   | expecting command byte (IMEM/DMEM)
// LEN0  | expecting length low byte
// LEN1  | expecting length high byte
// DATA  | assembling data words, one write per 4 bytes
// CSUM  | expecting checksum byte
// DONE  | one cycle, load_done pulse, release core
// ERR   | one cycle after an error, then back to IDLE
//
//   sys_clk    in   clock
//   sys_rst_n  in   asynchronous active-low reset
//   rx_done    in   receiver byte-complete level
//   rx_data    in   received byte
//   mem_we     out  one-cycle write strobe
//   mem_sel    out  0=IMEM, 1=DMEM
//   mem_addr   out  word address of the write
//   mem_wdata  out  write data
//   cpu_hold   out  1 = keep core in reset
//   load_done  out  one-cycle pulse on good frame
//   load_err   out  sticky error flag, cleared by next valid CMD
module uart_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W      = 14,
  parameter logic [7:0] SYNC_BYTE   = 8'h55,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              rx_done,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic              byte_evt;
  logic [7:0]        byte_data;

  state_t            state;
  logic [15:0]       len;
  logic [15:0]       word_cnt;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift;
  logic [7:0]        csum;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [ADDR_W-1:0] word_idx;
  logic              tmo_hit;

  byte_event_det u_evt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .byte_evt  (byte_evt),
    .byte_data (byte_data)
  );

  // Counter value one cycle before the gap reaches TIMEOUT_CYC.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      mem_we    <= 1'b0;
      mem_sel   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      cpu_hold  <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      len       <= 16'h0;
      word_cnt  <= 16'h0;
      byte_cnt  <= 2'd0;
      shift     <= 24'h0;
      csum      <= 8'h00;
      tmo_cnt   <= '0;
      word_idx  <= '0;
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (byte_evt && byte_data == SYNC_BYTE)
            state <= ST_CMD;
        end
        ST_DONE: begin
          tmo_cnt  <= '0;
          cpu_hold <= 1'b0;
          state    <= ST_IDLE;
        end
        ST_ERR: begin
          tmo_cnt <= '0;
          state   <= ST_IDLE;
        end
        default: begin
          // A byte in the same cycle as the timeout takes priority.
          if (byte_evt) begin
            tmo_cnt <= '0;
            case (state)
              ST_CMD: begin
                if (byte_data == CMD_IMEM || byte_data == CMD_DMEM) begin
                  mem_sel  <= (byte_data == CMD_DMEM);
                  cpu_hold <= 1'b1;
                  load_err <= 1'b0;
                  csum     <= byte_data;
                  word_idx <= '0;
                  word_cnt <= 16'h0;
                  byte_cnt <= 2'd0;
                  state    <= ST_LEN0;
                end else begin
                  load_err <= 1'b1;
                  cpu_hold <= 1'b0;
                  state    <= ST_ERR;
                end
              end
              ST_LEN0: begin
                len[7:0] <= byte_data;
                csum     <= csum ^ byte_data;
                state    <= ST_LEN1;
              end
              ST_LEN1: begin
                len[15:8] <= byte_data;
                csum      <= csum ^ byte_data;
                state     <= ({byte_data, len[7:0]} == 16'h0) ? ST_CSUM : ST_DATA;
              end
              ST_DATA: begin
                csum     <= csum ^ byte_data;
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                  mem_we    <= 1'b1;
                  mem_wdata <= {byte_data, shift};
                  mem_addr  <= word_idx;
                  word_idx  <= word_idx + 1'b1;
                  word_cnt  <= word_cnt + 16'd1;
                  if (word_cnt + 16'd1 == len)
                    state <= ST_CSUM;
                end else begin
                  shift[{byte_cnt, 3'b000} +: 8] <= byte_data;
                end
              end
              ST_CSUM: begin
                if (byte_data == csum) begin
                  load_done <= 1'b1;
                  state     <= ST_DONE;
                end else begin
                  load_err <= 1'b1;
                  cpu_hold <= 1'b0;
                  state    <= ST_ERR;
                end
              end
              default: state <= ST_IDLE;
            endcase
          end else if (tmo_hit) begin
            load_err <= 1'b1;
            cpu_hold <= 1'b0;
            state    <= ST_ERR;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader: stimulus pushes expected writes, done
// pulses and error rises into a queue; a monitor pops and compares them.
module tb_uart_loader;

  localparam int ADDR_W = 14;
  localparam int TMO    = 2000;

  localparam logic [1:0] EV_WR   = 2'd0;
  localparam logic [1:0] EV_DONE = 2'd1;
  localparam logic [1:0] EV_ERR  = 2'd2;

  typedef struct {
    logic [1:0]        kind;
    logic              sel;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              rx_done = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              mem_we;
  logic              mem_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  uart_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'h55), .TIMEOUT_CYC(TMO)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .mem_we    (mem_we),
    .mem_sel   (mem_sel),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_wr(input logic sel, input logic [ADDR_W-1:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = EV_WR; e.sel = sel; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  task automatic exp_ev(input logic [1:0] k);
    exp_t e;
    e.kind = k; e.sel = 1'b0; e.addr = '0; e.data = 32'h0;
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold = 2, input int gap = 4);
    @(posedge sys_clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    repeat (hold) @(posedge sys_clk);
    #1 rx_done = 1'b0;
    repeat (gap) @(posedge sys_clk);
  endtask

  task automatic pop_cmp(input logic [1:0] k);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", k, $time);
    end else begin
      e = sb.pop_front();
      chk("event_kind", 32'(k), 32'(e.kind));
      if (k == EV_WR && e.kind == EV_WR) begin
        chk("mem_sel", 32'(mem_sel), 32'(e.sel));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("mem_wdata", mem_wdata, e.data);
      end
    end
  endtask

  // Monitor
  initial begin
    logic prev_we, prev_err;
    prev_we = 1'b0;
    prev_err = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n) begin
        if (mem_we) begin
          chk("we_one_cycle", 32'(prev_we), 32'd0);
          pop_cmp(EV_WR);
        end
        if (load_done) pop_cmp(EV_DONE);
        if (load_err && !prev_err) pop_cmp(EV_ERR);
      end
      prev_we = mem_we;
      prev_err = load_err;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_sel"}, 32'(mem_sel), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
    chk({tag, "_load_done"}, 32'(load_done), 32'd0);
    chk({tag, "_load_err"}, 32'(load_err), 32'd0);
  endtask

  initial begin
    logic [7:0] f1 [13];
    logic [7:0] f2 [9];
    logic [7:0] f6 [9];

    #12;
    chk_all_zero("reset");
    @(negedge sys_clk) sys_rst_n = 1'b1;
    repeat (3) @(posedge sys_clk);

    // 1: two-word IMEM load, checksum 0x29
    f1 = '{8'h55, 8'h01, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h29};
    exp_wr(1'b0, 14'd0, 32'h12345678);
    exp_wr(1'b0, 14'd1, 32'hDEADBEEF);
    exp_ev(EV_DONE);
    for (int i = 0; i < 13; i++) begin
      send_byte(f1[i]);
      if (i == 1) chk("t1_hold_after_cmd", 32'(cpu_hold), 32'd1);
    end
    repeat (4) @(posedge sys_clk); #1;
    chk("t1_hold_released", 32'(cpu_hold), 32'd0);
    chk("t1_err_clear", 32'(load_err), 32'd0);

    // 3: garbage ignored, bad command errors out
    send_byte(8'hAA);
    send_byte(8'h00);
    chk("t3_garbage_no_hold", 32'(cpu_hold), 32'd0);
    exp_ev(EV_ERR);
    send_byte(8'h55);
    send_byte(8'h03);
    repeat (4) @(posedge sys_clk); #1;
    chk("t3_err_set", 32'(load_err), 32'd1);
    chk("t3_hold_low", 32'(cpu_hold), 32'd0);

    // 4: zero-length frame, done latency of two cycles after the event cycle
    exp_ev(EV_DONE);
    send_byte(8'h55);
    send_byte(8'h01);
    chk("t4_err_cleared_by_cmd", 32'(load_err), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    @(posedge sys_clk); #1;
    rx_data = 8'h01;
    rx_done = 1'b1;
    @(posedge sys_clk); #1;
    chk("t4_done_not_early", 32'(load_done), 32'd0);
    @(posedge sys_clk); #1;
    chk("t4_done_latency", 32'(load_done), 32'd1);
    rx_done = 1'b0;
    repeat (5) @(posedge sys_clk);

    // 2: one-word DMEM load with wrong checksum (good one is 0x47)
    f2 = '{8'h55, 8'h02, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    exp_wr(1'b1, 14'd0, 32'h44332211);
    exp_ev(EV_ERR);
    for (int i = 0; i < 9; i++) send_byte(f2[i]);
    repeat (20) @(posedge sys_clk); #1;
    chk("t2_err_sticky", 32'(load_err), 32'd1);
    chk("t2_hold_low", 32'(cpu_hold), 32'd0);

    // 5: stall after two data bytes, then a good frame (checksum 0x04)
    exp_ev(EV_ERR);
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    chk("t5_hold_in_frame", 32'(cpu_hold), 32'd1);
    repeat (TMO + 100) @(posedge sys_clk); #1;
    chk("t5_timeout_err", 32'(load_err), 32'd1);
    chk("t5_timeout_hold", 32'(cpu_hold), 32'd0);
    exp_wr(1'b0, 14'd0, 32'hD4C3B2A1);
    exp_ev(EV_DONE);
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    send_byte(8'h04);
    repeat (4) @(posedge sys_clk); #1;
    chk("t5_err_cleared", 32'(load_err), 32'd0);

    // 6: rx_done held 500 cycles per byte, DMEM word, checksum 0x03
    f6 = '{8'h55, 8'h02, 8'h01, 8'h00, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'h03};
    exp_wr(1'b1, 14'd0, 32'hF00FA55A);
    exp_ev(EV_DONE);
    for (int i = 0; i < 9; i++) send_byte(f6[i], 500, 4);
    repeat (4) @(posedge sys_clk);

    // 6b: reset in the middle of the second word
    exp_wr(1'b0, 14'd0, 32'h04030201);
    send_byte(8'h55);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h05);
    send_byte(8'h06);
    chk("t6_hold_before_rst", 32'(cpu_hold), 32'd1);
    #3 sys_rst_n = 1'b0;
    #1;
    chk_all_zero("t6_async_rst");
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk) sys_rst_n = 1'b1;
    repeat (50) @(posedge sys_clk);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
